// File: rtl/dm_port_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA/loader master.
// The CPU has priority; a DMA request that is denied for too long gets a short forced burst.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// CPU_PRI   | CPU wins collisions; wait_cnt counts denied DMA cycles
// DMA_FORCE | DMA wins collisions (CPU stalled) for up to BURST_MAX grants
module dm_port_arbiter #(
   parameter int MAX_WAIT  = 8,
   parameter int BURST_MAX = 4,
   parameter int AW        = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
   input  logic [3:0]    cpu_be,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [31:0]   dma_addr,
   input  logic [31:0]   dma_wdata,
   input  logic [3:0]    dma_be,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [31:0]   dma_rdata,
   output logic          dma_err,
   output logic [AW-1:0] dm_addr,
   output logic          dm_we,
   output logic [3:0]    dm_be,
   output logic [31:0]   dm_wdata,
   input  logic [31:0]   dm_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [31:0] DM_LAST = 32'h0000_2FFF;

   typedef enum logic {
      CPU_PRI   = 1'b0,
      DMA_FORCE = 1'b1
   } mode_t;

   mode_t         mode_q, mode_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [BW-1:0] burst_q, burst_d;

   logic dma_bad;
   logic dma_win;
   logic dma_sel;
   logic rd_return;
   logic unused_cpu_addr;

   // Upper and byte-lane address bits of the CPU side are never decoded here;
   // the MEM stage has already range- and alignment-checked them.
   assign unused_cpu_addr = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

   assign dma_bad = (dma_addr > DM_LAST) || (dma_addr[1:0] != 2'b00);
   assign dma_win = dma_req && (!cpu_req || (mode_q == DMA_FORCE));
   assign dma_sel = dma_win && !dma_bad;

   assign dma_gnt   = dma_win;
   assign cpu_stall = cpu_req && dma_win;
   assign cpu_rdata = dm_rdata;

   assign dm_addr  = dma_sel ? dma_addr[AW+1:2] : cpu_addr[AW+1:2];
   assign dm_be    = dma_sel ? dma_be : cpu_be;
   assign dm_wdata = dma_sel ? dma_wdata : cpu_wdata;
   assign dm_we    = dma_win ? (dma_we && !dma_bad) : (cpu_req && cpu_we);

   // Bad writes also return a response so the DMA engine always sees its error.
   assign rd_return = dma_win && (!dma_we || dma_bad);

   always_comb begin
      mode_d  = mode_q;
      wait_d  = wait_q;
      burst_d = burst_q;
      unique case (mode_q)
         CPU_PRI: begin
            if (dma_req && !dma_win) begin
               if (wait_q == WW'(MAX_WAIT - 1)) begin
                  mode_d  = DMA_FORCE;
                  wait_d  = '0;
                  burst_d = '0;
               end else if (wait_q != WW'(MAX_WAIT)) begin
                  wait_d = wait_q + WW'(1);
               end
            end else begin
               wait_d = '0;
            end
         end
         DMA_FORCE: begin
            if (!dma_req) begin
               mode_d = CPU_PRI;
               wait_d = '0;
            end else begin
               burst_d = burst_q + BW'(1);
               if (burst_q == BW'(BURST_MAX - 1)) begin
                  mode_d = CPU_PRI;
                  wait_d = '0;
               end
            end
         end
         default: begin
            mode_d = CPU_PRI;
            wait_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= CPU_PRI;
         wait_q     <= '0;
         burst_q    <= '0;
         dma_rvalid <= 1'b0;
         dma_err    <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         mode_q  <= mode_d;
         wait_q  <= wait_d;
         burst_q <= burst_d;
         if (rd_return) begin
            dma_rvalid <= 1'b1;
            dma_err    <= dma_bad;
            dma_rdata  <= dma_bad ? 32'h0 : dm_rdata;
         end else begin
            dma_rvalid <= 1'b0;
            dma_err    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios followed by constrained-random traffic,
// checked against a starvation/burst reference model and a shadow copy of DM.
module tb_dm_port_arbiter;

   localparam int MAX_WAIT  = 8;
   localparam int BURST_MAX = 4;
   localparam int AW        = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic [3:0]    cpu_be;
   logic [31:0]   cpu_rdata;
   logic          cpu_stall;
   logic          dma_req, dma_we;
   logic [31:0]   dma_addr, dma_wdata;
   logic [3:0]    dma_be;
   logic          dma_gnt, dma_rvalid, dma_err;
   logic [31:0]   dma_rdata;
   logic [AW-1:0] dm_addr;
   logic          dm_we;
   logic [3:0]    dm_be;
   logic [31:0]   dm_wdata, dm_rdata;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] dm_mem  [0:4095];
   logic [31:0] ref_mem [0:4095];

   int          starve;
   int          force_left;
   logic        exp_rvalid, exp_err;
   logic [31:0] exp_rdata;
   bit          reg_known;
   bit          m_gnt;
   logic        obs_gnt, obs_stall;

   always #5 clk = ~clk;

   dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_be(dma_be), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .dma_err(dma_err), .dm_addr(dm_addr), .dm_we(dm_we), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
   );

   assign dm_rdata = dm_mem[dm_addr];

   always @(posedge clk) begin
      if (dm_we === 1'b1)
         for (int b = 0; b < 4; b++)
            if (dm_be[b]) dm_mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ref_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
   endtask

   // One clock: check outputs at the falling edge, then advance the model past the rising edge.
   task automatic step();
      logic        bad, forced, gnt, stall, we;
      logic [11:0] a_exp, dma_w, cpu_w;
      @(negedge clk);
      bad    = (dma_addr > 32'h2FFF) || (dma_addr[1:0] != 2'b00);
      forced = (force_left > 0);
      gnt    = dma_req && (!cpu_req || forced);
      stall  = cpu_req && gnt;
      dma_w  = dma_addr[13:2];
      cpu_w  = cpu_addr[13:2];
      we     = gnt ? (dma_we && !bad) : (cpu_req && cpu_we);
      a_exp  = (gnt && !bad) ? dma_w : cpu_w;
      m_gnt  = gnt;
      obs_gnt   = dma_gnt;
      obs_stall = cpu_stall;
      check("dma_gnt", dma_gnt, gnt);
      check("cpu_stall", cpu_stall, stall);
      check("dm_we", dm_we, we);
      check("dm_addr", dm_addr, a_exp);
      if (we) begin
         check("dm_wdata", dm_wdata, gnt ? dma_wdata : cpu_wdata);
         check("dm_be", dm_be, gnt ? dma_be : cpu_be);
      end
      if (cpu_req && !stall) check("cpu_rdata", cpu_rdata, ref_mem[cpu_w]);
      if (reg_known) begin
         check("dma_rvalid", dma_rvalid, exp_rvalid);
         check("dma_err", dma_err, exp_err);
         check("dma_rdata", dma_rdata, exp_rdata);
      end
      @(posedge clk);
      #1;
      if (reset) begin
         starve = 0; force_left = 0;
         exp_rvalid = 0; exp_err = 0; exp_rdata = 0;
         reg_known = 1;
      end else begin
         if (gnt && (!dma_we || bad)) begin
            exp_rvalid = 1;
            exp_err    = bad;
            exp_rdata  = bad ? 32'h0 : ref_mem[dma_w];
         end else begin
            exp_rvalid = 0;
            exp_err    = 0;
         end
         if (forced) begin
            if (!dma_req) force_left = 0;
            else          force_left--;
            starve = 0;
         end else if (dma_req && !gnt) begin
            starve++;
            if (starve == MAX_WAIT) begin
               force_left = BURST_MAX;
               starve = 0;
            end
         end else begin
            starve = 0;
         end
      end
      if (we) begin
         if (gnt) ref_write(dma_w, dma_wdata, dma_be);
         else     ref_write(cpu_w, cpu_wdata, cpu_be);
      end
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 4'hF;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_be = 4'hF;
   endtask

   function automatic logic [31:0] rand_dma_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      return 32'h3000 + 32'($urandom_range(0, 255)) * 4;
      else if (r == 1) return 32'($urandom_range(0, 3071)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 2) return 32'hFFFF_FFFC;
      else             return 32'($urandom_range(0, 3071)) * 4;
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) begin
         dm_mem[i]  = $urandom;
         ref_mem[i] = dm_mem[i];
      end
      starve = 0; force_left = 0; reg_known = 0;
      exp_rvalid = 0; exp_err = 0; exp_rdata = 0;
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      step();
      reset = 0;
      check("rst_rvalid", dma_rvalid, 1'b0);
      check("rst_err", dma_err, 1'b0);
      check("rst_rdata", dma_rdata, 32'h0);
      step();

      // CPU store then load, no DMA
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_be = 4'hF;
      step();
      check("t1_stall", obs_stall, 1'b0);
      cpu_we = 0;
      step();
      check("t1_load", cpu_rdata, 32'hDEADBEEF);
      check("t1_dm_addr", dm_addr, 12'd4);

      // DMA read with CPU idle
      idle_inputs();
      dma_req = 1; dma_addr = 32'h20;
      step();
      check("t2_gnt", obs_gnt, 1'b1);
      check("t2_rvalid", dma_rvalid, 1'b1);
      check("t2_rdata", dma_rdata, ref_mem[8]);
      idle_inputs();
      step();

      // CPU saturates the port: 8 denied cycles, 4 forced grants, then CPU again
      cpu_req = 1; cpu_addr = 32'h100;
      dma_req = 1; dma_addr = 32'h40;
      for (int i = 0; i < 16; i++) begin
         step();
         check("t3_gnt", obs_gnt, (i >= 8 && i < 12) ? 1'b1 : 1'b0);
      end
      idle_inputs();
      step();

      // DMA read just above DM
      dma_req = 1; dma_addr = 32'h3000;
      step();
      check("t4_rvalid", dma_rvalid, 1'b1);
      check("t4_err", dma_err, 1'b1);
      check("t4_rdata", dma_rdata, 32'h0);
      idle_inputs();
      step();

      // Misaligned DMA write: denied against CPU in CPU_PRI, then erroring once granted
      cpu_req = 1; cpu_addr = 32'h200;
      dma_req = 1; dma_we = 1; dma_addr = 32'h22; dma_wdata = 32'h1234_5678;
      step();
      check("t5_gnt_cpu", obs_gnt, 1'b0);
      check("t5_stall_cpu", obs_stall, 1'b0);
      cpu_req = 0;
      step();
      check("t5_rvalid", dma_rvalid, 1'b1);
      check("t5_err", dma_err, 1'b1);
      idle_inputs();
      step();

      // Reset in the middle of a forced burst
      cpu_req = 1; cpu_addr = 32'h300;
      dma_req = 1; dma_addr = 32'h80;
      for (int i = 0; i < MAX_WAIT + 2; i++) step();
      reset = 1;
      step();
      reset = 0;
      check("t6_rvalid", dma_rvalid, 1'b0);
      check("t6_stall", cpu_stall, 1'b0);
      step();
      check("t6_gnt_after", obs_gnt, 1'b0);
      idle_inputs();
      step();

      // Constrained-random traffic
      for (int i = 0; i < 4000; i++) begin
         int cpu_pct;
         cpu_pct = (i < 1000) ? 30 : (i < 2000) ? 95 : (i < 3000) ? 60 : 85;
         reset = ($urandom_range(0, 199) == 0);
         cpu_req   = ($urandom_range(0, 99) < cpu_pct);
         cpu_we    = $urandom_range(0, 1);
         cpu_addr  = 32'($urandom_range(0, 3071)) * 4;
         cpu_wdata = $urandom;
         cpu_be    = 4'($urandom_range(1, 15));
         if (!dma_req || m_gnt) begin
            dma_req   = ($urandom_range(0, 99) < 60);
            dma_we    = $urandom_range(0, 1);
            dma_addr  = rand_dma_addr();
            dma_wdata = $urandom;
            dma_be    = 4'($urandom_range(1, 15));
         end
         step();
      end
      reset = 0;
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
